// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop synchronizer, mid-bit sampling and one-cycle strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2 - 1;
  localparam int CW   = $clog2(CPB);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, s2p_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
  logic bit_done, half_done;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
`endif
  assign bit_done  = cnt_q == CW'(CPB - 1);
  assign half_done = cnt_q == CW'(HALF);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s2p_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      s1_q    <= rx;
      s2_q    <= s1_q;
      s2p_q   <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = (s2p_q && !s2_q) ? START : IDLE;
      end
      START:
        if (half_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = s2_q ? IDLE : DATA;
        end
      DATA:
        if (bit_done) begin
          cnt_d          = '0;
          shift_d[idx_q] = s2_q;
          idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          state_d        = (idx_q == 3'd7) ? PARITY : DATA;
`else
          state_d        = (idx_q == 3'd7) ? STOP : DATA;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (bit_done) begin
          cnt_d   = '0;
          par_d   = s2_q;
          state_d = STOP;
        end
`endif
      STOP:
        if (bit_done) begin
          cnt_d   = '0;
          data_d  = s2_q ? shift_q : data_q;
          valid_d = s2_q;
          ferr_d  = !s2_q;
`ifdef UART_RX_PARITY_EN
          perr_d  = s2_q && ((^shift_q) ^ par_q);
`endif
          state_d = s2_q ? IDLE : WAIT_IDLE;
        end
      WAIT_IDLE: begin
        cnt_d   = '0;
        state_d = s2_q ? IDLE : WAIT_IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    data       = data_q;
    valid      = valid_q;
    frame_err  = ferr_q;
    parity_err = perr_q;
    busy       = state_q != IDLE;
  end
endmodule
